// File: rtl/driver_conf_scheduler.sv
// Periodic driver configuration write / readback-verify scheduler.
// A cycle writes the config once, then reads back and compares every SOUT chain.
module driver_conf_scheduler #(
  parameter int NB_CHAINS      = 30,
  parameter int CONF_BITS      = 48,
  parameter int REFRESH_FRAMES = 1024,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                 clk_lse,
  input  logic                 nrst,
  input  logic                 framebuffer_sync,
  input  logic                 blanking,
  input  logic [CONF_BITS-1:0] serialized_conf,
  input  logic                 force_refresh,
  output logic                 conf_req,
  input  logic                 conf_ack,
  output logic                 rb_req,
  input  logic                 rb_valid,
  input  logic                 rb_bit,
  output logic [4:0]           driver_sout_mux,
  output logic                 busy,
  output logic                 conf_error,
  output logic [4:0]           error_chain,
  output logic [2:0]           state_dbg
);

  localparam int FW = (REFRESH_FRAMES > 1) ? $clog2(REFRESH_FRAMES) : 1;
  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam int BW = $clog2(CONF_BITS + 1);
  localparam logic [4:0]    LAST_CHAIN = 5'(NB_CHAINS - 1);
  localparam logic [FW-1:0] LAST_FRAME = FW'(REFRESH_FRAMES - 1);
  localparam logic [RW-1:0] LAST_RETRY = RW'(MAX_RETRIES - 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(CONF_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_BLANK = 3'd1,
    S_WRITE      = 3'd2,
    S_MUX_SETTLE = 3'd3,
    S_READ       = 3'd4,
    S_CHECK      = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic                   pending_q, pending_d;
  logic [FW-1:0]          frame_cnt_q, frame_cnt_d;
  logic [RW-1:0]          retry_cnt_q, retry_cnt_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic                   settle_q, settle_d;
  logic [4:0]             chain_q, chain_d;
  logic [CONF_BITS-1:0]   shreg_q, shreg_d;
  logic                   mismatch_seen_q, mismatch_seen_d;
  logic [4:0]             first_chain_q, first_chain_d;
  logic                   conf_req_q, conf_req_d;
  logic                   rb_req_q, rb_req_d;
  logic [4:0]             mux_q, mux_d;
  logic                   busy_q, busy_d;
  logic                   conf_error_q, conf_error_d;
  logic [4:0]             error_chain_q, error_chain_d;
  logic                   set_pending, clr_pending, mismatch;

  always_comb begin
    state_d         = state_q;
    frame_cnt_d     = frame_cnt_q;
    retry_cnt_d     = retry_cnt_q;
    bit_cnt_d       = bit_cnt_q;
    settle_d        = settle_q;
    chain_d         = chain_q;
    shreg_d         = shreg_q;
    mismatch_seen_d = mismatch_seen_q;
    first_chain_d   = first_chain_q;
    conf_error_d    = conf_error_q;
    error_chain_d   = error_chain_q;
    mux_d           = mux_q;
    set_pending     = force_refresh;
    clr_pending     = 1'b0;
    mismatch        = (shreg_q != serialized_conf);

    // The frame counter runs independently of the FSM.
    if (framebuffer_sync) begin
      if (frame_cnt_q == LAST_FRAME) begin
        frame_cnt_d = '0;
        set_pending = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          state_d     = S_WAIT_BLANK;
          clr_pending = 1'b1;
        end
      end
      S_WAIT_BLANK: begin
        if (blanking) begin
          state_d         = S_WRITE;
          mismatch_seen_d = 1'b0;
        end
      end
      S_WRITE: begin
        if (conf_ack) begin
          state_d  = S_MUX_SETTLE;
          chain_d  = '0;
          settle_d = 1'b0;
        end
      end
      S_MUX_SETTLE: begin
        if (!settle_q) begin
          settle_d = 1'b1;
        end else if (blanking) begin
          state_d   = S_READ;
          bit_cnt_d = '0;
        end
      end
      S_READ: begin
        if (rb_valid) begin
          shreg_d = {shreg_q[CONF_BITS-2:0], rb_bit};
          if (bit_cnt_q == LAST_BIT) begin
            state_d = S_CHECK;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      S_CHECK: begin
        if (mismatch && !mismatch_seen_q) begin
          mismatch_seen_d = 1'b1;
          first_chain_d   = chain_q;
        end
        if (chain_q == LAST_CHAIN) begin
          state_d = S_IDLE;
          if (mismatch || mismatch_seen_q) begin
            if (retry_cnt_q == LAST_RETRY) begin
              conf_error_d  = 1'b1;
              error_chain_d = mismatch_seen_q ? first_chain_q : chain_q;
              retry_cnt_d   = '0;
            end else begin
              retry_cnt_d = retry_cnt_q + RW'(1);
              set_pending = 1'b1;
            end
          end else begin
            retry_cnt_d = '0;
          end
        end else begin
          chain_d  = chain_q + 5'd1;
          state_d  = S_MUX_SETTLE;
          settle_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A set arriving on the clearing cycle wins so the request is not lost.
    pending_d  = (pending_q & ~clr_pending) | set_pending;
    conf_req_d = (state_d == S_WRITE);
    rb_req_d   = (state_d == S_READ);
    busy_d     = (state_d != S_IDLE);
    if (state_d == S_MUX_SETTLE || state_d == S_READ) mux_d = chain_d;
  end

  always_ff @(posedge clk_lse or negedge nrst) begin
    if (!nrst) begin
      state_q         <= S_IDLE;
      pending_q       <= 1'b1;
      frame_cnt_q     <= '0;
      retry_cnt_q     <= '0;
      bit_cnt_q       <= '0;
      settle_q        <= 1'b0;
      chain_q         <= '0;
      shreg_q         <= '0;
      mismatch_seen_q <= 1'b0;
      first_chain_q   <= '0;
      conf_req_q      <= 1'b0;
      rb_req_q        <= 1'b0;
      mux_q           <= '0;
      busy_q          <= 1'b0;
      conf_error_q    <= 1'b0;
      error_chain_q   <= '0;
    end else begin
      state_q         <= state_d;
      pending_q       <= pending_d;
      frame_cnt_q     <= frame_cnt_d;
      retry_cnt_q     <= retry_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      settle_q        <= settle_d;
      chain_q         <= chain_d;
      shreg_q         <= shreg_d;
      mismatch_seen_q <= mismatch_seen_d;
      first_chain_q   <= first_chain_d;
      conf_req_q      <= conf_req_d;
      rb_req_q        <= rb_req_d;
      mux_q           <= mux_d;
      busy_q          <= busy_d;
      conf_error_q    <= conf_error_d;
      error_chain_q   <= error_chain_d;
    end
  end

  assign conf_req        = conf_req_q;
  assign rb_req          = rb_req_q;
  assign driver_sout_mux = mux_q;
  assign busy            = busy_q;
  assign conf_error      = conf_error_q;
  assign error_chain     = error_chain_q;
  assign state_dbg       = state_q;

endmodule
